// File: rtl/cpstr_mgr_tx_prio.sv
// cpstr_mgr_tx_prio: multiplexes NUM_STREAMS byte streams into one SLIP-framed byte stream.
// Latency: first data byte is on o_data 4 clocks after i_valid rises from idle; then 1 byte/clock.
// Backpressure: i_ready low freezes the FSM and holds o_data/o_valid; o_ready is low while stalled.
// Ports: i_data/i_valid/o_ready  per-stream byte inputs, stream k at i_data[8k+7:8k]
//        i_prio                  high-priority mask, sampled at each arbitration and byte boundary
//        i_send_stridx           resend the MARK + index header at the next byte boundary
//        o_data/o_valid/i_ready  registered framed output
// Optional feature: define CPSTR_MGR_TX_KEEPALIVE_EN to emit a lone MARK after KEEPALIVE_CYCLES idle cycles.
module cpstr_mgr_tx_prio #(
   parameter int         NUM_STREAMS          = 4,
   parameter int         MAX_BURST            = 127,
   parameter int         KEEPALIVE_CYCLES     = 1024,
   parameter logic [7:0] SLIP_SYMBOL_MARK     = 8'hC0,
   parameter logic [7:0] SLIP_SYMBOL_ESC      = 8'hDB,
   parameter logic [7:0] SLIP_SYMBOL_ESC_MARK = 8'hDC,
   parameter logic [7:0] SLIP_SYMBOL_ESC_ESC  = 8'hDD
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [8*NUM_STREAMS-1:0] i_data,
   input  logic [NUM_STREAMS-1:0]   i_valid,
   output logic [NUM_STREAMS-1:0]   o_ready,
   input  logic [NUM_STREAMS-1:0]   i_prio,
   input  logic                     i_send_stridx,
   output logic [7:0]               o_data,
   output logic                     o_valid,
   input  logic                     i_ready
);

   localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   if (NUM_STREAMS < 2 || NUM_STREAMS > 16 || MAX_BURST < 2 || MAX_BURST > 255 ||
       KEEPALIVE_CYCLES < 1) begin : g_bad_param
      $error("cpstr_mgr_tx_prio: parameter out of range");
   end

   typedef enum logic [2:0] {
      ARB, HDR_MARK, HDR_IDX, HDR_ESC2, ROUTE, DATA_ESC2
   } state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    grant_idx, grant_idx_nxt;
   logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
   logic [7:0]       burst_cnt, burst_cnt_nxt;
   logic             esc_mark, esc_mark_nxt;   // pending second escape byte is ESC_MARK (else ESC_ESC)
   logic             load;
   logic [7:0]       data_nxt;
   logic             slot_free;
   logic [NUM_STREAMS-1:0] hi_valid, eligible, grant_oh, others;
   logic [IW-1:0]    cand, pick_idx;
   logic             pick_vld;
   logic             grant_valid, grant_prio, at_max;
   logic [7:0]       idx_byte, grant_byte;

   assign slot_free   = !o_valid || i_ready;
   assign hi_valid    = i_valid & i_prio;
   // High-priority streams, when any are valid, shadow every normal stream.
   assign eligible    = (|hi_valid) ? hi_valid : i_valid;
   assign grant_valid = i_valid[grant_idx];
   assign grant_prio  = i_prio[grant_idx];
   assign grant_byte  = i_data[{grant_idx, 3'b000} +: 8];
   assign idx_byte    = 8'(grant_idx);
   assign at_max      = (burst_cnt == 8'(MAX_BURST));
   assign others      = eligible & ~grant_oh;

   always_comb begin
      grant_oh = '0;
      for (int k = 0; k < NUM_STREAMS; k++) grant_oh[k] = (grant_idx == IW'(k));
   end

   // Round-robin search starting one past the last grant.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 1; k <= NUM_STREAMS; k++) begin
         cand = IW'((int'(rr_ptr) + k) % NUM_STREAMS);
         if (!pick_vld && eligible[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

`ifdef CPSTR_MGR_TX_KEEPALIVE_EN
   localparam int KW = $clog2(KEEPALIVE_CYCLES + 1);
   logic [KW-1:0] ka_cnt, ka_cnt_nxt;
`endif

   always_comb begin
      state_nxt     = state;
      grant_idx_nxt = grant_idx;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      esc_mark_nxt  = esc_mark;
      load          = 1'b0;
      data_nxt      = o_data;
      o_ready       = '0;
      if (slot_free) begin
         case (state)
            ARB: begin
               if (pick_vld) begin
                  grant_idx_nxt = pick_idx;
                  rr_ptr_nxt    = pick_idx;
                  state_nxt     = HDR_MARK;
               end
            end
            HDR_MARK: begin
               load      = 1'b1;
               data_nxt  = SLIP_SYMBOL_MARK;
               state_nxt = HDR_IDX;
            end
            HDR_IDX: begin
               load          = 1'b1;
               burst_cnt_nxt = '0;
               if (idx_byte == SLIP_SYMBOL_MARK || idx_byte == SLIP_SYMBOL_ESC) begin
                  data_nxt     = SLIP_SYMBOL_ESC;
                  esc_mark_nxt = (idx_byte == SLIP_SYMBOL_MARK);
                  state_nxt    = HDR_ESC2;
               end else begin
                  data_nxt  = idx_byte;
                  state_nxt = ROUTE;
               end
            end
            HDR_ESC2, DATA_ESC2: begin
               load      = 1'b1;
               data_nxt  = esc_mark ? SLIP_SYMBOL_ESC_MARK : SLIP_SYMBOL_ESC_ESC;
               state_nxt = ROUTE;
               if (state == HDR_ESC2) burst_cnt_nxt = '0;
            end
            ROUTE: begin
               // Byte boundary: leave for arbitration, resend header, or keep streaming.
               if (|others && (at_max || !grant_valid || (!grant_prio && |hi_valid))) begin
                  state_nxt = ARB;
               end else if (i_send_stridx) begin
                  state_nxt = HDR_MARK;
               end else begin
                  o_ready = grant_oh;
                  if (at_max) burst_cnt_nxt = '0;
                  if (grant_valid) begin
                     load          = 1'b1;
                     burst_cnt_nxt = (at_max ? 8'd0 : burst_cnt) + 8'd1;
                     if (grant_byte == SLIP_SYMBOL_MARK || grant_byte == SLIP_SYMBOL_ESC) begin
                        data_nxt     = SLIP_SYMBOL_ESC;
                        esc_mark_nxt = (grant_byte == SLIP_SYMBOL_MARK);
                        state_nxt    = DATA_ESC2;
                     end else begin
                        data_nxt = grant_byte;
                     end
                  end
               end
            end
            default: state_nxt = ARB;
         endcase
      end
`ifdef CPSTR_MGR_TX_KEEPALIVE_EN
      ka_cnt_nxt = ka_cnt;
      if (o_ready != '0 && grant_valid) begin
         ka_cnt_nxt = '0;
      end else if (!o_valid && !(|i_valid) && (state == ARB || state == ROUTE)) begin
         if (ka_cnt == KW'(KEEPALIVE_CYCLES - 1)) begin
            // Lone MARK; returning to ARB forces a full header before the next data.
            load       = 1'b1;
            data_nxt   = SLIP_SYMBOL_MARK;
            ka_cnt_nxt = '0;
            state_nxt  = ARB;
         end else begin
            ka_cnt_nxt = ka_cnt + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ARB;
         grant_idx <= '0;
         rr_ptr    <= IW'(NUM_STREAMS - 1);
         burst_cnt <= '0;
         esc_mark  <= 1'b0;
         o_valid   <= 1'b0;
         o_data    <= 8'h00;
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_idx_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
         esc_mark  <= esc_mark_nxt;
         if (slot_free) begin
            o_valid <= load;
            if (load) o_data <= data_nxt;
         end
      end
   end

`ifdef CPSTR_MGR_TX_KEEPALIVE_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ka_cnt <= '0;
      else          ka_cnt <= ka_cnt_nxt;
   end
`endif

endmodule

// File: tb/tb_cpstr_mgr_tx_prio.sv
// tb_cpstr_mgr_tx_prio: self-checking bench for cpstr_mgr_tx_prio (4 streams, MAX_BURST=4).
// Expected byte streams come from a SLIP frame encoder and a SLIP decoder kept in the bench.
// One task per scenario; each compares inline and steps the shared counters.
module tb_cpstr_mgr_tx_prio;
   localparam int NS = 4;
   localparam int MB = 4;
   localparam logic [7:0] MARK  = 8'hC0;
   localparam logic [7:0] ESC   = 8'hDB;
   localparam logic [7:0] EMARK = 8'hDC;
   localparam logic [7:0] EESC  = 8'hDD;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [8*NS-1:0] i_data;
   logic [NS-1:0]   i_valid, o_ready, i_prio;
   logic            i_send_stridx;
   logic [7:0]      o_data;
   logic            o_valid, i_ready;

   always #5 clk = ~clk;

   cpstr_mgr_tx_prio #(.NUM_STREAMS(NS), .MAX_BURST(MB), .KEEPALIVE_CYCLES(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
      .i_prio(i_prio), .i_send_stridx(i_send_stridx), .o_data(o_data), .o_valid(o_valid),
      .i_ready(i_ready));

   int vecs = 0;
   int miss = 0;

   logic [7:0] src_mem [NS][1024];
   int         src_len [NS];
   int         src_rd  [NS];
   logic [7:0] out_mem [8192];
   int         out_cnt;
   logic [7:0] exp_mem [512];
   int         exp_cnt;
   logic [7:0] dec_mem [NS][1024];
   int         dec_cnt [NS];

   logic          rand_rdy, gap_en, stridx_v;
   logic [NS-1:0] prio_v;
   logic          prev_stall;
   logic [7:0]    prev_data;
   int            stall_bad, oh_bad;
   logic          w_valid;
   logic [7:0]    w_data;
   logic [NS-1:0] w_rdy;

   task automatic clear_logs();
      for (int k = 0; k < NS; k++) begin
         src_len[k] = 0; src_rd[k] = 0; dec_cnt[k] = 0;
      end
      out_cnt = 0; exp_cnt = 0; stall_bad = 0; oh_bad = 0; prev_stall = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      i_valid = '0; i_data = '0; i_prio = '0; i_send_stridx = 1'b0; i_ready = 1'b1;
      rand_rdy = 1'b0; gap_en = 1'b0; stridx_v = 1'b0; prio_v = '0;
      clear_logs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // One clock: drive inputs from the source queues, sample outputs, log handshakes.
   task automatic cycle();
      @(negedge clk);
      i_ready = rand_rdy ? 1'($urandom_range(0, 9) < 7) : 1'b1;
      i_prio = prio_v;
      i_send_stridx = stridx_v;
      for (int k = 0; k < NS; k++) begin
         if (src_rd[k] < src_len[k]) begin
            i_data[8*k +: 8] = src_mem[k][src_rd[k]];
            i_valid[k] = gap_en ? 1'($urandom_range(0, 3) != 0) : 1'b1;
         end else begin
            i_data[8*k +: 8] = 8'h00;
            i_valid[k] = 1'b0;
         end
      end
      #1;
      w_valid = o_valid; w_data = o_data; w_rdy = o_ready;
      if (!$onehot0(o_ready)) oh_bad++;
      if (prev_stall && (o_valid !== 1'b1 || o_data !== prev_data)) stall_bad++;
      prev_stall = o_valid && !i_ready;
      prev_data = o_data;
      if (o_valid && i_ready && out_cnt < 8192) begin
         out_mem[out_cnt] = o_data;
         out_cnt++;
      end
      for (int k = 0; k < NS; k++)
         if (i_valid[k] && o_ready[k]) src_rd[k]++;
   endtask

   function automatic bit all_done();
      for (int k = 0; k < NS; k++) if (src_rd[k] < src_len[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_until_done(input int budget, output bit done);
      int idle = 0;
      int n = 0;
      while (idle < 3 && n < budget) begin
         cycle();
         n++;
         if (all_done() && !w_valid) idle++; else idle = 0;
      end
      done = (idle >= 3);
   endtask

   task automatic push_exp(input logic [7:0] b);
      exp_mem[exp_cnt] = b;
      exp_cnt++;
   endtask

   task automatic push_esc(input logic [7:0] b);
      if (b == MARK) begin push_exp(ESC); push_exp(EMARK); end
      else if (b == ESC) begin push_exp(ESC); push_exp(EESC); end
      else push_exp(b);
   endtask

   // One frame: MARK, escaped stream index, escaped source bytes [from,to).
   task automatic enc_frame(input int s, input int from, input int to);
      push_exp(MARK);
      push_esc(8'(s));
      for (int i = from; i < to; i++) push_esc(src_mem[s][i]);
   endtask

   task automatic test_reset();
      do_reset();
      vecs++; if (o_valid !== 1'b0) begin miss++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
      vecs++; if (o_data !== 8'h00) begin miss++; $display("FAIL reset_o_data: got %h want 00", o_data); end
      vecs++; if (o_ready !== 4'b0000) begin miss++; $display("FAIL reset_o_ready: got %b want 0000", o_ready); end
   endtask

   task automatic test_latency_escape();
      logic          v [9];
      logic [7:0]    d [9];
      logic [NS-1:0] r [9];
      logic [7:0]    want [6] = '{8'hC0, 8'h01, 8'h11, 8'hDB, 8'hDC, 8'h22};
      do_reset();
      src_mem[1][0] = 8'h11; src_mem[1][1] = 8'hC0; src_mem[1][2] = 8'h22; src_len[1] = 3;
      for (int n = 0; n < 9; n++) begin
         cycle();
         v[n] = w_valid; d[n] = w_data; r[n] = w_rdy;
      end
      vecs++; if (v[1] !== 1'b0) begin miss++; $display("FAIL lat_edge1_valid: got %b want 0", v[1]); end
      for (int i = 0; i < 6; i++) begin
         vecs++;
         if (v[i+2] !== 1'b1 || d[i+2] !== want[i]) begin
            miss++; $display("FAIL lat_byte%0d: got v=%b d=%h want v=1 d=%h", i, v[i+2], d[i+2], want[i]);
         end
      end
      vecs++; if (r[2] !== 4'b0000) begin miss++; $display("FAIL lat_ready_hdr: got %b want 0000", r[2]); end
      vecs++; if (r[3] !== 4'b0010) begin miss++; $display("FAIL lat_ready_first: got %b want 0010", r[3]); end
      vecs++; if (r[5] !== 4'b0000) begin miss++; $display("FAIL lat_ready_esc2: got %b want 0000", r[5]); end
   endtask

   task automatic test_back_to_back();
      bit done;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         src_mem[0][i] = 8'($urandom); src_mem[2][i] = 8'($urandom);
      end
      src_len[0] = 12; src_len[2] = 12;
      for (int b = 0; b < 3; b++) begin
         enc_frame(0, 4*b, 4*b + 4);
         enc_frame(2, 4*b, 4*b + 4);
      end
      run_until_done(500, done);
      vecs++; if (!done) begin miss++; $display("FAIL b2b_timeout: done=%b want 1", done); end
      vecs++; if (out_cnt !== exp_cnt) begin miss++; $display("FAIL b2b_len: got %0d want %0d", out_cnt, exp_cnt); end
      for (int i = 0; i < exp_cnt && i < out_cnt; i++) begin
         vecs++;
         if (out_mem[i] !== exp_mem[i]) begin miss++; $display("FAIL b2b_byte%0d: got %h want %h", i, out_mem[i], exp_mem[i]); end
      end
   endtask

   task automatic test_single_stream_burst();
      bit done;
      do_reset();
      for (int i = 0; i < 10; i++) src_mem[0][i] = 8'($urandom);
      src_len[0] = 10;
      enc_frame(0, 0, 10);
      run_until_done(300, done);
      vecs++; if (!done) begin miss++; $display("FAIL single_timeout: done=%b want 1", done); end
      vecs++; if (out_cnt !== exp_cnt) begin miss++; $display("FAIL single_len: got %0d want %0d", out_cnt, exp_cnt); end
      for (int i = 0; i < exp_cnt && i < out_cnt; i++) begin
         vecs++;
         if (out_mem[i] !== exp_mem[i]) begin miss++; $display("FAIL single_byte%0d: got %h want %h", i, out_mem[i], exp_mem[i]); end
      end
   endtask

   task automatic test_preempt();
      bit done;
      int n = 0;
      int k_inj = -1;
      do_reset();
      for (int i = 0; i < 6; i++) src_mem[0][i] = 8'($urandom);
      src_mem[0][1] = ESC;              // the preempted byte needs its second escape byte first
      for (int i = 0; i < 3; i++) src_mem[3][i] = 8'($urandom);
      src_len[0] = 6;
      while (k_inj < 0 && n < 100) begin
         if (src_rd[0] >= 2) begin
            k_inj = src_rd[0];
            src_len[3] = 3;
            prio_v = 4'b1000;
         end
         cycle();
         n++;
      end
      vecs++; if (k_inj !== 2) begin miss++; $display("FAIL preempt_inject: got %0d want 2", k_inj); end
      if (k_inj < 0) k_inj = 0;
      enc_frame(0, 0, k_inj);
      enc_frame(3, 0, 3);
      enc_frame(0, k_inj, 6);
      run_until_done(300, done);
      vecs++; if (!done) begin miss++; $display("FAIL preempt_timeout: done=%b want 1", done); end
      vecs++; if (out_cnt !== exp_cnt) begin miss++; $display("FAIL preempt_len: got %0d want %0d", out_cnt, exp_cnt); end
      for (int i = 0; i < exp_cnt && i < out_cnt; i++) begin
         vecs++;
         if (out_mem[i] !== exp_mem[i]) begin miss++; $display("FAIL preempt_byte%0d: got %h want %h", i, out_mem[i], exp_mem[i]); end
      end
   endtask

   task automatic test_send_stridx();
      bit done;
      int n = 0;
      bit sent = 0;
      do_reset();
      for (int i = 0; i < 4; i++) src_mem[2][i] = 8'($urandom_range(0, 8'hBF));
      src_len[2] = 4;
      while (!sent && n < 100) begin
         if (src_rd[2] >= 2) begin
            stridx_v = 1'b1;
            sent = 1;
         end
         cycle();
         stridx_v = 1'b0;
         n++;
      end
      enc_frame(2, 0, 2);
      enc_frame(2, 2, 4);
      run_until_done(300, done);
      vecs++; if (!done) begin miss++; $display("FAIL stridx_timeout: done=%b want 1", done); end
      vecs++; if (out_cnt !== exp_cnt) begin miss++; $display("FAIL stridx_len: got %0d want %0d", out_cnt, exp_cnt); end
      for (int i = 0; i < exp_cnt && i < out_cnt; i++) begin
         vecs++;
         if (out_mem[i] !== exp_mem[i]) begin miss++; $display("FAIL stridx_byte%0d: got %h want %h", i, out_mem[i], exp_mem[i]); end
      end
   endtask

   task automatic test_reset_midframe();
      bit done;
      do_reset();
      for (int i = 0; i < 8; i++) src_mem[3][i] = 8'($urandom);
      src_len[3] = 8;
      repeat (6) cycle();
      do_reset();
      vecs++; if (o_valid !== 1'b0) begin miss++; $display("FAIL midreset_valid: got %b want 0", o_valid); end
      // Both streams valid together: stream 0 has first preference after reset.
      for (int i = 0; i < 2; i++) begin
         src_mem[0][i] = 8'($urandom); src_mem[1][i] = 8'($urandom);
      end
      src_len[0] = 2; src_len[1] = 2;
      enc_frame(0, 0, 2);
      enc_frame(1, 0, 2);
      run_until_done(300, done);
      vecs++; if (!done) begin miss++; $display("FAIL midreset_timeout: done=%b want 1", done); end
      vecs++; if (out_cnt !== exp_cnt) begin miss++; $display("FAIL midreset_len: got %0d want %0d", out_cnt, exp_cnt); end
      for (int i = 0; i < exp_cnt && i < out_cnt; i++) begin
         vecs++;
         if (out_mem[i] !== exp_mem[i]) begin miss++; $display("FAIL midreset_byte%0d: got %h want %h", i, out_mem[i], exp_mem[i]); end
      end
   endtask

   task automatic test_random_stall();
      bit         done;
      int         cur = -1;
      bit         hdr = 0;
      bit         esc = 0;
      logic [7:0] b, v;
      do_reset();
      src_len[0] = 333; src_len[1] = 333; src_len[2] = 334;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < src_len[k]; i++) src_mem[k][i] = 8'($urandom);
      rand_rdy = 1'b1;
      gap_en = 1'b1;
      prio_v = 4'b0010;
      run_until_done(40000, done);
      vecs++; if (!done) begin miss++; $display("FAIL random_timeout: done=%b want 1", done); end
      vecs++; if (oh_bad !== 0) begin miss++; $display("FAIL random_ready_onehot: %0d bad cycles, want 0", oh_bad); end
      vecs++; if (stall_bad !== 0) begin miss++; $display("FAIL random_stall_hold: %0d unstable stalls, want 0", stall_bad); end
      // SLIP decode of the captured output into per-stream byte sequences.
      for (int i = 0; i < out_cnt; i++) begin
         b = out_mem[i];
         if (b == MARK) begin
            hdr = 1; esc = 0;
         end else if (b == ESC) begin
            esc = 1;
         end else begin
            v = b;
            if (esc) v = (b == EMARK) ? MARK : (b == EESC) ? ESC : b;
            esc = 0;
            if (hdr) begin
               cur = int'(v); hdr = 0;
            end else if (cur >= 0 && cur < NS && dec_cnt[cur] < 1024) begin
               dec_mem[cur][dec_cnt[cur]] = v;
               dec_cnt[cur]++;
            end
         end
      end
      for (int k = 0; k < NS; k++) begin
         vecs++;
         if (dec_cnt[k] !== src_len[k]) begin miss++; $display("FAIL random_len_s%0d: got %0d want %0d", k, dec_cnt[k], src_len[k]); end
         for (int i = 0; i < src_len[k] && i < dec_cnt[k]; i++) begin
            vecs++;
            if (dec_mem[k][i] !== src_mem[k][i]) begin
               miss++; $display("FAIL random_s%0d_byte%0d: got %h want %h", k, i, dec_mem[k][i], src_mem[k][i]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      i_valid = '0; i_data = '0; i_prio = '0; i_send_stridx = 1'b0; i_ready = 1'b1;
      rand_rdy = 1'b0; gap_en = 1'b0; stridx_v = 1'b0; prio_v = '0;
      clear_logs();
      test_reset();
      test_latency_escape();
      test_back_to_back();
      test_single_stream_burst();
      test_preempt();
      test_send_stridx();
      test_reset_midframe();
      test_random_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
